subleq_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 1024 x 32 Subleq data memory between the Subleq core (port A) and a host loader/debug port (port B). It serialises accesses through a three-state sequencer, drives the memory's address/write-enable/write-data pins from registers, and returns read data with a one-cycle acknowledge. It sits between the core and the memory, so the host can preload or inspect memory without tristating or muxing in the bench.

---
 rtl/subleq_mem_arbiter.sv | 104 ++++++++++
 tb/tb_subleq_mem_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/subleq_mem_arbiter.sv
// Two-port arbiter sharing the single-port Subleq data memory between the core (A) and host (B).
// Memory pins are driven from registers; each access takes IDLE -> ACCESS -> RESP.
module subleq_mem_arbiter #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 32,
  parameter bit HOST_PRIORITY = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_ack_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_ack_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  // state     | meaning
  // ST_IDLE   | sample requests, grant a winner
  // ST_ACCESS | memory sees the registered pins (write commits at closing edge)
  // ST_RESP   | owner's ack pulses, memory read data returned
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              win;
  logic              resp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;  // B, so A wins the first tie
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    win         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (a_req_i || b_req_i) begin
          if (a_req_i && b_req_i) win = HOST_PRIORITY ? 1'b1 : ~last_q;
          else                    win = b_req_i;
          owner_d     = win;
          last_d      = win;
          mem_addr_d  = win ? b_addr_i  : a_addr_i;
          mem_we_d    = win ? b_we_i    : a_we_i;
          mem_wdata_d = win ? b_wdata_i : a_wdata_i;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_we_d = 1'b0;
        state_d  = ST_RESP;
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign resp        = (state_q == ST_RESP);
  assign a_ack_o     = resp & ~owner_q;
  assign b_ack_o     = resp &  owner_q;
  assign a_rdata_o   = a_ack_o ? mem_rdata_i : '0;
  assign b_rdata_o   = b_ack_o ? mem_rdata_i : '0;
  assign busy_o      = (state_q != ST_IDLE);
  assign owner_o     = owner_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// Directed bench: two arbiters (round-robin and host-priority), each with its own memory model.
module tb_subleq_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // round-robin instance (u0) signals
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack, mem_we, busy, owner;
  logic [DW-1:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  // host-priority instance (u1) signals
  logic          h_a_req, h_b_req;
  logic          h_a_ack, h_b_ack, h_mem_we, h_busy, h_owner;
  logic [DW-1:0] h_a_rdata, h_b_rdata, h_mem_wdata, h_mem_rdata;
  logic [AW-1:0] h_mem_addr;

  logic [DW-1:0] mem0 [0:1023];
  logic [DW-1:0] mem1 [0:1023];

  int checks = 0;
  int errors = 0;

  subleq_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_PRIORITY(1'b0)) u0 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_ack_o(a_ack), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_ack_o(b_ack), .b_rdata_o(b_rdata),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .owner_o(owner));

  subleq_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_PRIORITY(1'b1)) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(h_a_req), .a_we_i(1'b0), .a_addr_i(10'd1), .a_wdata_i(32'h0),
    .a_ack_o(h_a_ack), .a_rdata_o(h_a_rdata),
    .b_req_i(h_b_req), .b_we_i(1'b0), .b_addr_i(10'd2), .b_wdata_i(32'h0),
    .b_ack_o(h_b_ack), .b_rdata_o(h_b_rdata),
    .mem_addr_o(h_mem_addr), .mem_we_o(h_mem_we), .mem_wdata_o(h_mem_wdata),
    .mem_rdata_i(h_mem_rdata), .busy_o(h_busy), .owner_o(h_owner));

  // synchronous single-port memories: read data registered, valid the cycle after the address
  always @(posedge clk) begin
    if (mem_we) mem0[mem_addr] <= mem_wdata;
    mem_rdata <= mem0[mem_addr];
    if (h_mem_we) mem1[h_mem_addr] <= h_mem_wdata;
    h_mem_rdata <= mem1[h_mem_addr];
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    h_a_req = 0; h_b_req = 0;
    for (int i = 0; i < 1024; i++) begin mem0[i] = '0; mem1[i] = '0; end
    mem0[1] = 32'h0000_0011; mem0[2] = 32'h0000_0022; mem0[9] = 32'h0000_0099;
    mem1[1] = 32'h0000_00A1; mem1[2] = 32'h0000_00B2;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // reset values
    chk("rst_busy", busy, 0);   chk("rst_owner", owner, 0);
    chk("rst_mem_we", mem_we, 0); chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_a_ack", a_ack, 0); chk("rst_b_ack", b_ack, 0);

    // A writes 0xFF to addr 5
    a_req = 1; a_we = 1; a_addr = 5; a_wdata = 32'h0000_00FF;
    tick();
    a_req = 0; a_we = 0;
    chk("wrA_mem_we", mem_we, 1); chk("wrA_mem_addr", mem_addr, 5);
    chk("wrA_mem_wdata", mem_wdata, 32'hFF); chk("wrA_busy", busy, 1);
    chk("wrA_early_ack", a_ack, 0);
    tick();
    chk("wrA_a_ack", a_ack, 1); chk("wrA_b_ack", b_ack, 0);
    chk("wrA_we_off", mem_we, 0); chk("wrA_mem5", mem0[5], 32'hFF);
    tick();
    chk("wrA_ack_end", a_ack, 0); chk("wrA_idle", busy, 0);

    // B reads addr 5
    b_req = 1; b_we = 0; b_addr = 5;
    tick();
    b_req = 0;
    chk("rdB_owner", owner, 1); chk("rdB_mem_we", mem_we, 0);
    tick();
    chk("rdB_b_ack", b_ack, 1); chk("rdB_rdata", b_rdata, 32'hFF);
    chk("rdB_a_ack", a_ack, 0);
    tick();
    chk("rdB_ack_end", b_ack, 0);

    // continuous contention, round-robin: A, B, A, B
    a_req = 1; a_we = 0; a_addr = 1;
    b_req = 1; b_we = 0; b_addr = 2;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_owner", owner, (k % 2 == 0) ? 0 : 1);
      chk("rr_no_ack", a_ack | b_ack, 0);
      tick();
      chk("rr_a_ack", a_ack, (k % 2 == 0) ? 1 : 0);
      chk("rr_b_ack", b_ack, (k % 2 == 0) ? 0 : 1);
      chk("rr_rdata", (k % 2 == 0) ? a_rdata : b_rdata,
          (k % 2 == 0) ? 32'h11 : 32'h22);
      tick();
      chk("rr_gap", a_ack | b_ack, 0);
    end
    a_req = 0; b_req = 0;

    // host-priority instance: B wins every tie, A waits until B drops
    h_a_req = 1; h_b_req = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hp_owner", h_owner, 1);
      tick();
      chk("hp_b_ack", h_b_ack, 1); chk("hp_a_ack", h_a_ack, 0);
      chk("hp_rdata", h_b_rdata, 32'hB2);
      tick();
    end
    h_b_req = 0;
    tick();
    chk("hp_owner_a", h_owner, 0);
    h_a_req = 0;
    tick();
    chk("hp_a_ack_late", h_a_ack, 1); chk("hp_a_rdata", h_a_rdata, 32'hA1);
    tick();

    // reset during ACCESS of a write: aborted, nothing commits
    a_req = 1; a_we = 1; a_addr = 9; a_wdata = 32'hDEAD_BEEF;
    tick();
    chk("abort_we_before", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_we", mem_we, 0); chk("abort_busy", busy, 0);
    chk("abort_addr", mem_addr, 0); chk("abort_wdata", mem_wdata, 0);
    chk("abort_owner", owner, 0);
    a_req = 0; a_we = 0;
    tick();
    chk("abort_ack", a_ack | b_ack, 0);
    rst_n = 1'b1;
    tick();
    chk("abort_mem9", mem0[9], 32'h99); chk("abort_ack2", a_ack | b_ack, 0);

    // A drops req during ACCESS; ack still pulses, then B gets the next grant
    a_req = 1; a_we = 0; a_addr = 1;
    tick();
    a_req = 0;
    b_req = 1; b_we = 0; b_addr = 2;
    chk("drop_owner", owner, 0);
    tick();
    chk("drop_a_ack", a_ack, 1); chk("drop_a_rdata", a_rdata, 32'h11);
    chk("drop_b_held", b_ack, 0);
    tick();
    chk("drop_idle", busy, 0);
    tick();
    b_req = 0;
    chk("drop_b_owner", owner, 1); chk("drop_b_busy", busy, 1);
    tick();
    chk("drop_b_ack", b_ack, 1); chk("drop_b_rdata", b_rdata, 32'h22);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
